// File: rtl/dat_mem_arb.sv
// Port arbiter for the single-port 8x256 data memory: CPU accesses get priority,
// and a byte-by-byte copy engine runs in the gaps with a starvation guard.
module dat_mem_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic [7:0] cpu_rdata,
    input  logic       dma_start,
    input  logic [7:0] dma_src,
    input  logic [7:0] dma_dst,
    input  logic [7:0] dma_len,
    output logic       dma_busy,
    output logic       dma_done,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout
);

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_src_ptr, w_src_ptr_next;
    logic [7:0] r_dst_ptr, w_dst_ptr_next;
    logic [7:0] r_cnt, w_cnt_next;
    logic [7:0] r_buf, w_buf_next;
    logic [3:0] r_starve, w_starve_next;
    logic       w_engine_active;
    logic       w_dma_owns;

    assign w_engine_active = (r_state == ST_READ) || (r_state == ST_WRITE);
    // The engine takes the port when the CPU is quiet, or when it has waited long enough.
    assign w_dma_owns = w_engine_active && (!cpu_req || (r_starve == LP_LIMIT));

    assign cpu_gnt   = cpu_req & ~w_dma_owns;
    assign cpu_rdata = mem_dout;
    assign dma_busy  = w_engine_active;
    assign dma_done  = (r_state == ST_DONE);

    always_comb begin
        mem_addr  = cpu_addr;
        mem_din   = cpu_wdata;
        mem_wr_en = cpu_req & cpu_wr;
        if (w_dma_owns) begin
            if (r_state == ST_READ) begin
                mem_addr  = r_src_ptr;
                mem_wr_en = 1'b0;
            end else begin
                mem_addr  = r_dst_ptr;
                mem_din   = r_buf;
                mem_wr_en = 1'b1;
            end
        end
        if (reset) begin
            mem_wr_en = 1'b0;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_src_ptr_next = r_src_ptr;
        w_dst_ptr_next = r_dst_ptr;
        w_cnt_next     = r_cnt;
        w_buf_next     = r_buf;
        w_starve_next  = 4'd0;
        unique case (r_state)
            ST_IDLE: begin
                if (dma_start) begin
                    w_src_ptr_next = dma_src;
                    w_dst_ptr_next = dma_dst;
                    w_cnt_next     = dma_len;
                    w_state_next   = (dma_len != 8'd0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                if (w_dma_owns) begin
                    w_buf_next     = mem_dout;
                    w_src_ptr_next = r_src_ptr + 8'd1;
                    w_state_next   = ST_WRITE;
                end else begin
                    w_starve_next = r_starve + 4'd1;
                end
            end
            ST_WRITE: begin
                if (w_dma_owns) begin
                    w_dst_ptr_next = r_dst_ptr + 8'd1;
                    w_cnt_next     = r_cnt - 8'd1;
                    w_state_next   = (r_cnt == 8'd1) ? ST_DONE : ST_READ;
                end else begin
                    w_starve_next = r_starve + 4'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_src_ptr <= 8'd0;
            r_dst_ptr <= 8'd0;
            r_cnt     <= 8'd0;
            r_buf     <= 8'd0;
            r_starve  <= 4'd0;
        end else begin
            r_state   <= w_state_next;
            r_src_ptr <= w_src_ptr_next;
            r_dst_ptr <= w_dst_ptr_next;
            r_cnt     <= w_cnt_next;
            r_buf     <= w_buf_next;
            r_starve  <= w_starve_next;
        end
    end

endmodule

// File: tb/tb_dat_mem_arb.sv
// Scoreboard bench for dat_mem_arb: drivers push expected loads, engine memory
// operations and completions; a negedge monitor pops and compares them.
module tb_dat_mem_arb;

    localparam int SL = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_wr;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt;
    logic [7:0] cpu_rdata;
    logic       dma_start;
    logic [7:0] dma_src, dma_dst, dma_len;
    logic       dma_busy, dma_done;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    always #5 clk = ~clk;

    dat_mem_arb #(.STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
        .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
        .dma_busy(dma_busy), .dma_done(dma_done),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Data memory attached to the arbiter
    logic [7:0] mem [256];
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_din;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } mem_op_t;

    typedef struct {
        int cyc;
        int busy;
    } done_t;

    logic [7:0] ref_mem [256];
    mem_op_t    op_q[$];
    logic [7:0] load_q[$];
    done_t      done_q[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  done_cnt = 0;
    int  busy_cnt = 0;
    bit  pat_chk  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input bit ok, input string name,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endfunction

    always @(negedge clk) begin : monitor
        mem_op_t    e;
        done_t      d;
        logic [7:0] ld;
        if (reset) begin
            check(mem_wr_en === 1'b0, "wr_en_in_reset", 32'(mem_wr_en), 32'd0);
            busy_cnt = 0;
        end else begin
            if (cpu_req && cpu_gnt) begin
                check(mem_addr === cpu_addr && mem_wr_en === cpu_wr, "cpu_port",
                      {23'd0, mem_wr_en, mem_addr}, {23'd0, cpu_wr, cpu_addr});
                if (!cpu_wr) begin
                    check(load_q.size() != 0, "load_unexpected", 32'(load_q.size()), 32'd1);
                    if (load_q.size() != 0) begin
                        ld = load_q.pop_front();
                        check(cpu_rdata === ld, "cpu_rdata", 32'(cpu_rdata), 32'(ld));
                    end
                end
            end else if (dma_busy) begin
                check(op_q.size() != 0, "engine_op_unexpected", 32'(op_q.size()), 32'd1);
                if (op_q.size() != 0) begin
                    e = op_q.pop_front();
                    check(mem_wr_en === e.wr && mem_addr === e.addr && (!e.wr || mem_din === e.data),
                          "engine_op", {15'd0, mem_wr_en, mem_addr, mem_din}, {15'd0, e.wr, e.addr, e.data});
                end
            end else begin
                check(cpu_req == 1'b0 && mem_wr_en === 1'b0, "idle_port",
                      {30'd0, cpu_req, mem_wr_en}, 32'd0);
            end
            if (pat_chk && dma_busy)
                check(cpu_gnt === ((busy_cnt % (SL + 1)) != SL), "starve_gnt",
                      32'(cpu_gnt), 32'((busy_cnt % (SL + 1)) != SL));
            if (dma_busy) busy_cnt++;
            if (dma_done) begin
                check(done_q.size() != 0, "done_unexpected", 32'(done_q.size()), 32'd1);
                if (done_q.size() != 0) begin
                    d = done_q.pop_front();
                    if (d.cyc >= 0) check(cyc == d.cyc, "done_cycle", 32'(cyc), 32'(d.cyc));
                    if (d.busy >= 0) check(busy_cnt == d.busy, "busy_cycles", 32'(busy_cnt), 32'(d.busy));
                end
                busy_cnt = 0;
                done_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
    endtask

    // Issue one CPU access and hold it until granted.
    task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [7:0] d);
        bit g;
        int k;
        cpu_req   = 1'b1;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        if (wr) ref_mem[a] = d;
        else    load_q.push_back(ref_mem[a]);
        g = 1'b0;
        k = 0;
        while (!g && k < 64) begin
            @(negedge clk);
            g = cpu_gnt;
            @(posedge clk);
            #1;
            k++;
        end
        check(g, "cpu_grant_timeout", 32'(g), 32'd1);
    endtask

    task automatic readback(input logic [7:0] a, input int n);
        for (int i = 0; i < n; i++) cpu_op(1'b0, a + 8'(i), 8'h00);
        cpu_idle();
        tick();
    endtask

    // Reference copy: forward byte order on the model memory, wrapping mod 256.
    task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                            input int exp_off, input int exp_busy);
        int         c0, d0, k;
        logic [7:0] s, t;
        c0 = cyc;
        d0 = done_cnt;
        $display("copy src=0x%02h dst=0x%02h len=%0d start_cyc=%0d", src, dst, len, c0);
        for (int i = 0; i < int'(len); i++) begin
            s = src + 8'(i);
            t = dst + 8'(i);
            ref_mem[t] = ref_mem[s];
            op_q.push_back('{1'b0, s, 8'h00});
            op_q.push_back('{1'b1, t, ref_mem[t]});
        end
        done_q.push_back('{(exp_off < 0) ? -1 : c0 + exp_off, exp_busy});
        dma_start = 1'b1;
        dma_src   = src;
        dma_dst   = dst;
        dma_len   = len;
        tick();
        dma_start = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 3000) begin
            tick();
            k++;
        end
        check(done_cnt != d0, "done_timeout", 32'(done_cnt - d0), 32'd1);
    endtask

    // CPU traffic confined to 0xC0..0xFF until the copy in flight completes.
    task automatic cpu_traffic(input int d0, input bit bursty);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 2000) begin
            if (bursty && ($urandom % 3 == 0)) begin
                cpu_idle();
                repeat ($urandom_range(1, 3)) tick();
            end else begin
                cpu_op(1'(($urandom % 2)), 8'hC0 | 8'($urandom % 64), 8'($urandom));
            end
            k++;
        end
        cpu_idle();
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b1;
        cpu_wr    = 1'b1;
        cpu_addr  = 8'h33;
        cpu_wdata = 8'h77;
        dma_start = 1'b0;
        dma_src   = 8'h00;
        dma_dst   = 8'h00;
        dma_len   = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        check(cpu_gnt === cpu_req, "reset_gnt", 32'(cpu_gnt), 32'(cpu_req));
        check(dma_busy === 1'b0 && dma_done === 1'b0, "reset_busy_done",
              {30'd0, dma_busy, dma_done}, 32'd0);
        tick();
        reset = 1'b0;
        cpu_idle();
        tick();

        // CPU store then load, zero latency
        cpu_op(1'b1, 8'h10, 8'h5A);
        cpu_op(1'b0, 8'h10, 8'h00);
        cpu_idle();
        tick();

        for (int i = 0; i < 256; i++) cpu_op(1'b1, 8'(i), 8'($urandom));
        for (int i = 0; i < 4; i++) cpu_op(1'b1, 8'h20 + 8'(i), 8'(i + 1));
        cpu_idle();
        tick();

        // Uncontended copy, then wrap-around copy
        run_copy(8'h20, 8'h80, 8'd4, 9, 8);
        readback(8'h80, 4);
        run_copy(8'hFE, 8'h01, 8'd3, 7, 6);
        readback(8'h01, 3);

        // CPU requesting on every cycle: engine steps once per SL+1 cycles
        pat_chk = 1'b1;
        fork
            run_copy(8'h50, 8'hB0, 8'd4, 2 * 4 * (SL + 1) + 1, 2 * 4 * (SL + 1));
            cpu_traffic(done_cnt, 1'b0);
        join
        pat_chk = 1'b0;
        tick();
        readback(8'hB0, 4);

        // Zero-length copy, then a start issued while busy
        run_copy(8'h10, 8'h11, 8'd0, 1, 0);
        repeat (3) tick();
        fork
            run_copy(8'h30, 8'hA0, 8'd3, 7, 6);
            begin
                repeat (3) tick();
                dma_start = 1'b1;
                dma_len   = 8'd5;
                tick();
                dma_start = 1'b0;
            end
        join
        repeat (6) tick();
        readback(8'hA0, 3);
        readback(8'h11, 1);

        // Reset during the write of byte 2 of 4
        begin
            int c0;
            c0 = cyc;
            $display("copy src=0x40 dst=0x90 len=4 start_cyc=%0d (reset mid-copy)", c0);
            op_q.push_back('{1'b0, 8'h40, 8'h00});
            op_q.push_back('{1'b1, 8'h90, ref_mem[8'h40]});
            op_q.push_back('{1'b0, 8'h41, 8'h00});
            ref_mem[8'h90] = ref_mem[8'h40];
            dma_start = 1'b1;
            dma_src   = 8'h40;
            dma_dst   = 8'h90;
            dma_len   = 8'd4;
            tick();
            dma_start = 1'b0;
            repeat (3) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            @(negedge clk);
            check(dma_busy === 1'b0 && dma_done === 1'b0, "post_reset_idle",
                  {30'd0, dma_busy, dma_done}, 32'd0);
            check(op_q.size() == 0, "ops_before_reset", 32'(op_q.size()), 32'd0);
            op_q.delete();
            repeat (4) tick();
            readback(8'h90, 4);
        end

        // Randomized copies with concurrent CPU traffic
        for (int it = 0; it < 12; it++) begin
            logic [7:0] s, t, n;
            s = 8'($urandom_range(0, 8'h5F));
            t = 8'($urandom_range(0, 8'h5F));
            n = 8'($urandom_range(1, 32));
            fork
                run_copy(s, t, n, -1, -1);
                cpu_traffic(done_cnt, 1'b1);
            join
            tick();
            readback(t, int'(n));
            readback(8'hC0 | 8'($urandom % 64), 2);
        end

        repeat (4) tick();
        check(op_q.size() == 0, "op_q_drained", 32'(op_q.size()), 32'd0);
        check(load_q.size() == 0, "load_q_drained", 32'(load_q.size()), 32'd0);
        check(done_q.size() == 0, "done_q_drained", 32'(done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dat_mem_arb.md
# dat_mem_arb

Port arbiter and block-copy sequencer for the single-port 8x256 data memory. It sits between the CPU load/store path and the data memory. It grants the memory port to CPU accesses and, in the gaps, runs a byte-by-byte copy engine (src→dst, len bytes). A starvation guard guarantees copy progress under continuous CPU traffic.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive CPU-stalled copy cycles before the copy engine takes the port for one cycle; legal 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU requests the memory port this cycle
- cpu_wr  in  1  1 = store, 0 = load
- cpu_addr  in  8  CPU address
- cpu_wdata  in  8  CPU store data
- cpu_gnt  out  1  CPU owns the port this cycle; combinational
- cpu_rdata  out  8  = mem_dout; valid only when cpu_gnt=1 and cpu_wr=0
- dma_start  in  1  start pulse, sampled only in IDLE
- dma_src  in  8  source base, latched on accepted start
- dma_dst  in  8  destination base, latched on accepted start
- dma_len  in  8  byte count, latched on accepted start; 0 = no transfer
- dma_busy  out  1  high in READ/WRITE
- dma_done  out  1  one-cycle completion pulse
- mem_addr  out  8  to memory addr
- mem_wr_en  out  1  to memory write enable
- mem_din  out  8  to memory write data
- mem_dout  in  8  from memory; combinational read of mem_addr

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: src_ptr, dst_ptr (8b), cnt (8b), buf (8b), starve (4b).
- IDLE: on dma_start=1, latch src/dst/len. If len≠0, go to READ, else go to DONE. A start seen in any other state is ignored (no queueing).
- Port owner each cycle: the copy engine owns the port if state∈{READ,WRITE} and (cpu_req=0 or starve==STARVE_LIMIT). Otherwise the CPU owns it. cpu_gnt = cpu_req & ~dma_owns.
- CPU owns: mem_addr=cpu_addr, mem_din=cpu_wdata, mem_wr_en=cpu_wr & cpu_req.
- READ owned: mem_addr=src_ptr, mem_wr_en=0. At the edge, buf←mem_dout, src_ptr←src_ptr+1, go to WRITE.
- WRITE owned: mem_addr=dst_ptr, mem_din=buf, mem_wr_en=1. At the edge, dst_ptr+1, cnt−1. If cnt==1, go to DONE; else go to READ.
- Engine in READ/WRITE but not owner (stall): state, pointers and buf hold; starve+1.
- Engine is owner: starve←0. starve is also 0 in IDLE/DONE.
- DONE: dma_done=1 for one cycle, then go to IDLE.
- Pointers wrap mod 256 (0xFF+1=0x00). Copy is strictly forward byte order. An overlapping region with dst>src propagates source bytes; this is defined behaviour.
- A CPU store to a not-yet-read src byte is visible to the copy. A CPU store to an already-written dst byte overwrites it.
- Idle port (no cpu_req, no engine ownership): mem_addr=cpu_addr, mem_wr_en=0.
- mem_wr_en is forced 0 while reset=1.

## Timing
- Reset values: state=IDLE; dma_busy=0, dma_done=0, src/dst/cnt/buf/starve=0; cpu_gnt=cpu_req (combinational); mem_wr_en=0.
- CPU access is zero-latency: a granted load returns data the same cycle, and a granted store commits at that edge.
- CPU denied (cpu_gnt=0): the CPU must hold cpu_req, cpu_wr, cpu_addr and cpu_wdata until granted.
- Uncontended copy, start sampled at edge k: dma_busy high in cycles k+1..k+2N, dma_done high in cycle k+2N+1, back in IDLE at k+2N+2. Earliest next start is sampled at edge k+2N+2.
- len=0: dma_done high in cycle k+1, dma_busy never high.
- With cpu_req held high, the engine advances one step every STARVE_LIMIT+1 cycles; the CPU is denied only on that step.
- Reset mid-copy: at the next edge go to IDLE with no dma_done pulse. Bytes already written remain in memory.

## Test plan
- Reset, then CPU store 0x5A to 0x10 and load 0x10 → cpu_gnt=1 both cycles, cpu_rdata=0x5A same cycle as the load.
- Preload 0x20..0x23 = 1,2,3,4; copy src=0x20, dst=0x80, len=4, no CPU traffic → busy for 8 cycles, done on the 9th cycle after start, 0x80..0x83 = 1,2,3,4.
- Copy src=0xFE, dst=0x01, len=3 → reads 0xFE,0xFF,0x00 and writes 0x01,0x02,0x03 in order (wrap check).
- Copy len=4 with cpu_req held high throughout, STARVE_LIMIT=4 → cpu_gnt=0 exactly every 5th cycle, done after 40 busy cycles, data correct.
- dma_start with len=0 → done pulse next cycle, no memory write, busy stays 0. dma_start during busy → ignored, no second done.
- Assert reset during the WRITE of byte 2 of 4 → no done pulse; byte 1 is copied; bytes 3–4 are unchanged; IDLE afterwards.
